// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 1024x768 @ 60 Hz raster counter (65 MHz pixel clock).
// Emits the pixel column/line counts plus hsync/vsync/hblnk/vblnk. All outputs are
// registered together, so they always describe the same pixel.
// Optional feature: define VGA_FRAME_TICK_EN to add the frame_tick output, a
// one-cycle pulse on every (0,0) reached by a frame wrap.
// The game_pkg timing constants are kept in this file so the block is self-contained.

package game_pkg;
    localparam int H_COUNT_TOT  = 1344;
    localparam int H_BLNK_START = 1024;
    localparam int H_SYNC_START = 1048;
    localparam int H_SYNC_END   = 1184;
    localparam int V_COUNT_TOT  = 806;
    localparam int V_BLNK_START = 768;
    localparam int V_SYNC_START = 771;
    localparam int V_SYNC_END   = 777;
endpackage

module vga_timing_gen
    import game_pkg::*;
#(
    parameter int H_TOT    = H_COUNT_TOT,
    parameter int H_BLNK_S = H_BLNK_START,
    parameter int H_SYNC_S = H_SYNC_START,
    parameter int H_SYNC_E = H_SYNC_END,
    parameter int V_TOT    = V_COUNT_TOT,
    parameter int V_BLNK_S = V_BLNK_START,
    parameter int V_SYNC_S = V_SYNC_START,
    parameter int V_SYNC_E = V_SYNC_END
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic        frame_tick
`endif
);

    // The ordering blank < sync start < sync end <= total is what keeps each
    // strobe a single contiguous window inside the line/frame. Totals must also
    // fit the 11-bit counters.
    if (!(H_BLNK_S < H_SYNC_S && H_SYNC_S < H_SYNC_E && H_SYNC_E <= H_TOT)) begin : g_bad_h_timing
        $error("vga_timing_gen: illegal horizontal timing parameters");
    end
    if (!(V_BLNK_S < V_SYNC_S && V_SYNC_S < V_SYNC_E && V_SYNC_E <= V_TOT)) begin : g_bad_v_timing
        $error("vga_timing_gen: illegal vertical timing parameters");
    end
    if (H_TOT < 2 || H_TOT > 2048 || V_TOT < 2 || V_TOT > 2048) begin : g_bad_totals
        $error("vga_timing_gen: totals must lie in 2..2048");
    end

    // Timing constants sized to the counters so every compare is 11 bits wide.
    localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] H_BS   = 11'(H_BLNK_S);
    localparam logic [10:0] H_SS   = 11'(H_SYNC_S);
    localparam logic [10:0] H_SE   = 11'(H_SYNC_E);
    localparam logic [10:0] V_LAST = 11'(V_TOT - 1);
    localparam logic [10:0] V_BS   = 11'(V_BLNK_S);
    localparam logic [10:0] V_SS   = 11'(V_SYNC_S);
    localparam logic [10:0] V_SE   = 11'(V_SYNC_E);

    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        h_wrap;
    logic        v_wrap;
    logic        hsync_nxt;
    logic        vsync_nxt;
    logic        hblnk_nxt;
    logic        vblnk_nxt;

    // Next raster position; the line counter only moves when the pixel counter wraps.
    always_comb begin
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_nxt  = h_wrap ? 11'd0 : hcount + 11'd1;
        v_nxt  = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? 11'd0 : vcount + 11'd1;
        end
    end

    // Strobes decoded from the next position so they register in step with the counts.
    always_comb begin
        hblnk_nxt = (h_nxt >= H_BS);
        hsync_nxt = (h_nxt >= H_SS) && (h_nxt < H_SE);
        vblnk_nxt = (v_nxt >= V_BS);
        vsync_nxt = (v_nxt >= V_SS) && (v_nxt < V_SE);
    end

    // Raster state register; reset parks everything at (0,0) with strobes low.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount <= 11'd0;
            vcount <= 11'd0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hblnk  <= 1'b0;
            vblnk  <= 1'b0;
        end else begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            hsync  <= hsync_nxt;
            vsync  <= vsync_nxt;
            hblnk  <= hblnk_nxt;
            vblnk  <= vblnk_nxt;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Pulse only on a (0,0) reached by wrapping from the last pixel, never on the
    // (0,0) produced by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= h_wrap && v_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one default-timing instance and one reduced-timing
// instance (so whole frames fit in a short run), both checked every cycle against
// a position model n = edges since reset, with h = n mod H_TOT, v = (n / H_TOT) mod V_TOT.
module tb_vga_timing_gen;

    localparam int SH  = 50, SHB = 32, SHS = 36, SHE = 42;
    localparam int SV  = 30, SVB = 24, SVS = 25, SVE = 27;
    localparam int DH  = 1344, DHB = 1024, DHS = 1048, DHE = 1184;
    localparam int DV  = 806,  DVB = 768,  DVS = 771,  DVE = 777;

    logic        clk = 1'b0;
    logic        rst_d, rst_s;
    logic [10:0] hc_d, vc_d, hc_s, vc_s;
    logic        hs_d, vs_d, hb_d, vb_d;
    logic        hs_s, vs_s, hb_s, vb_s;
`ifdef VGA_FRAME_TICK_EN
    logic        ft_d, ft_s;
`endif

    always #5 clk = ~clk;

    vga_timing_gen u_dut_def (
        .clk(clk), .rst(rst_d), .hcount(hc_d), .vcount(vc_d),
        .hsync(hs_d), .vsync(vs_d), .hblnk(hb_d), .vblnk(vb_d)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_d)
`endif
    );

    vga_timing_gen #(
        .H_TOT(SH), .H_BLNK_S(SHB), .H_SYNC_S(SHS), .H_SYNC_E(SHE),
        .V_TOT(SV), .V_BLNK_S(SVB), .V_SYNC_S(SVS), .V_SYNC_E(SVE)
    ) u_dut_small (
        .clk(clk), .rst(rst_s), .hcount(hc_s), .vcount(vc_s),
        .hsync(hs_s), .vsync(vs_s), .hblnk(hb_s), .vblnk(vb_s)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(ft_s)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int n_d = 0, n_s = 0;
    int cyc = 0;
    bit phase_a = 1'b0;
    int hold_d = 0, hold_s = 0;
    int run_hs = 0, run_hb = 0;
    int vis_acc = 0, vs_acc = 0, last00 = -1, ft_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_dut(input string pfx, input int n,
                             input int ht, input int hbs, input int hss, input int hse,
                             input int vt, input int vbs, input int vss, input int vse,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hs, input logic vs, input logic hb, input logic vb,
                             input logic ft);
        int h, v;
        h = n % ht;
        v = (n / ht) % vt;
        chk({pfx, "_hcount"}, 32'(hc), 32'(h));
        chk({pfx, "_vcount"}, 32'(vc), 32'(v));
        chk({pfx, "_hblnk"}, 32'(hb), 32'(h >= hbs));
        chk({pfx, "_hsync"}, 32'(hs), 32'(h >= hss && h < hse));
        chk({pfx, "_vblnk"}, 32'(vb), 32'(v >= vbs));
        chk({pfx, "_vsync"}, 32'(vs), 32'(v >= vss && v < vse));
`ifdef VGA_FRAME_TICK_EN
        chk({pfx, "_frame_tick"}, 32'(ft), 32'(n > 0 && (n % (ht * vt)) == 0));
`else
        if (ft !== 1'b0) chk({pfx, "_frame_tick"}, 32'(ft), 32'd0);
`endif
    endtask

    task automatic measure();
        // default instance: sync and blank window widths
        if (hs_d) run_hs++;
        else if (run_hs > 0) begin
            chk("d_hsync_width", run_hs, 136);
            chk("d_hsync_fall_at", 32'(hc_d), 1184);
            run_hs = 0;
        end
        if (hb_d) run_hb++;
        else if (run_hb > 0) begin
            chk("d_hblnk_width", run_hb, 320);
            chk("d_hblnk_fall_at", 32'(hc_d), 0);
            run_hb = 0;
        end
        // small instance: per-frame totals between successive (0,0) states
        if (hc_s == 11'd0 && vc_s == 11'd0) begin
            if (last00 >= 0) begin
                chk("s_frame_len", cyc - last00, SH * SV);
                chk("s_visible", vis_acc, SHB * SVB);
                chk("s_vsync_cycles", vs_acc, (SVE - SVS) * SH);
            end
            last00  = cyc;
            vis_acc = 0;
            vs_acc  = 0;
        end
        if (!hb_s && !vb_s) vis_acc++;
        if (vs_s) vs_acc++;
`ifdef VGA_FRAME_TICK_EN
        if (ft_s && n_s < 3 * SH * SV) ft_cnt++;
`endif
    endtask

    task automatic step();
        logic fd, fs;
        @(posedge clk);
        n_d = rst_d ? 0 : n_d + 1;
        n_s = rst_s ? 0 : n_s + 1;
        @(negedge clk);
        cyc++;
`ifdef VGA_FRAME_TICK_EN
        fd = ft_d;
        fs = ft_s;
`else
        fd = 1'b0;
        fs = 1'b0;
`endif
        check_dut("d", n_d, DH, DHB, DHS, DHE, DV, DVB, DVS, DVE,
                  hc_d, vc_d, hs_d, vs_d, hb_d, vb_d, fd);
        check_dut("s", n_s, SH, SHB, SHS, SHE, SV, SVB, SVS, SVE,
                  hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, fs);
        if (phase_a) measure();
    endtask

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (5) step();
        chk("reset_hcount", 32'(hc_d), 0);
        chk("reset_strobes", 32'({hs_d, vs_d, hb_d, vb_d}), 0);
        rst_d = 1'b0;
        rst_s = 1'b0;
        step();
        chk("release_hcount", 32'(hc_d), 1);
        chk("release_vcount", 32'(vc_d), 0);
        chk("release_strobes", 32'({hs_d, vs_d, hb_d, vb_d}), 0);

        phase_a = 1'b1;
        repeat (10000) step();
        phase_a = 1'b0;
`ifdef VGA_FRAME_TICK_EN
        chk("s_tick_count_3frames", ft_cnt, 2);
`endif

        // random reset pulses of 1..3 cycles, independent per instance
        repeat (40000) begin
            if (hold_d > 0) hold_d--;
            else if ($urandom_range(0, 1499) == 0) hold_d = $urandom_range(1, 3);
            if (hold_s > 0) hold_s--;
            else if ($urandom_range(0, 999) == 0) hold_s = $urandom_range(1, 3);
            rst_d = (hold_d > 0);
            rst_s = (hold_s > 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster counter for 1024x768 @ 60 Hz, 65 MHz pixel clock.
- Produces the horizontal and vertical pixel counts plus sync and blanking strobes.
- All downstream draw stages (background, sprites, game screens selected by game_state) consume these outputs.
- Timing defaults equal the game_pkg horizontal/vertical constants; the block imports game_pkg for them.

Parameters:
- H_TOT, default H_COUNT_TOT (1344): pixels per line.
- H_BLNK_S, default H_BLNK_START (1024): first blanked pixel.
- H_SYNC_S, default H_SYNC_START (1048): first hsync pixel.
- H_SYNC_E, default H_SYNC_END (1184): first pixel after hsync.
- V_TOT, default V_COUNT_TOT (806): lines per frame.
- V_BLNK_S, default V_BLNK_START (768): first blanked line.
- V_SYNC_S, default V_SYNC_START (771): first vsync line.
- V_SYNC_E, default V_SYNC_END (777): first line after vsync.

Ports:
- clk  in  1  65 MHz pixel clock.
- rst  in  1  synchronous, active-high reset.
- hcount  out  11  current pixel column, 0..H_TOT-1.
- vcount  out  11  current line, 0..V_TOT-1.
- hsync  out  1  horizontal sync, active-high.
- vsync  out  1  vertical sync, active-high.
- hblnk  out  1  horizontal blanking.
- vblnk  out  1  vertical blanking.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are registered; no combinational path from input to output.
- Reset: on any rising edge of clk with rst=1, hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0.
- Reset mid-frame takes effect on the next edge and restarts the raster at (0,0). No partial state survives reset.
- Counting, per edge with rst=0:
  - hcount = (hcount==H_TOT-1) ? 0 : hcount+1.
  - vcount advances only when hcount wraps: vcount = (vcount==V_TOT-1) ? 0 : vcount+1.
  - Simultaneous wrap at (1343,805) goes to (0,0).
- Strobes are computed from the next-state counts and registered alongside them, so every output describes the same pixel in the same cycle (zero skew, latency 0 relative to the counts):
  - hblnk=1 iff hcount >= H_BLNK_S (1024..1343, 320 pixels).
  - hsync=1 iff H_SYNC_S <= hcount < H_SYNC_E (1048..1183, 136 pixels).
  - vblnk=1 iff vcount >= V_BLNK_S (768..805, 38 lines).
  - vsync=1 iff V_SYNC_S <= vcount < V_SYNC_E (771..776, 6 lines).
- The visible area is hblnk=0 and vblnk=0, giving exactly 1024x768 pixels per frame.
- Frame length is exactly H_TOT*V_TOT = 1 083 264 clocks.
- Counter widths: 11 bits; values never exceed TOT-1.
- Parameter legality, checked with an elaboration-time assertion: BLNK_S < SYNC_S < SYNC_E <= TOT.
- Sync polarity inversion for the connector is out of scope (done at the top level).

Optional Feature:
- Macro VGA_FRAME_TICK_EN.
- When defined: adds output port frame_tick (out, 1).
  - Registered; 1 for exactly the one cycle in which hcount=0 and vcount=0 following a wrap.
  - Not asserted during reset or during the first (0,0) cycle after reset release.
  - Used by the game FSM to update game_state once per frame.
- When undefined: port absent; no extra logic.

Test Plan:
- Reset: hold rst=1 for 5 cycles, release -> all outputs 0 during reset; the first edge after release gives hcount=1, vcount=0, all strobes 0.
- Horizontal edges: run 1 line -> hblnk rises at hcount=1024 and falls at hcount=0; hsync is high exactly for 1048..1183 (136 cycles); hcount wraps 1343->0 and vcount goes 0->1 in the same cycle.
- Vertical edges: run 1 frame -> vblnk high for lines 768..805; vsync high for lines 771..776 (6*1344 = 8064 cycles); the visible pixel count with hblnk=0 and vblnk=0 equals 786 432.
- Frame wrap: count cycles between successive (0,0) states -> exactly 1 083 264; at (1343,805) the next state is (0,0).
- Reset mid-operation: assert rst at (500,400) for 1 cycle -> the next state is (0,0) with all strobes 0, and the counts resume normally from there.
- With VGA_FRAME_TICK_EN: run 3 frames -> frame_tick pulses exactly twice, each 1 cycle wide and coincident with hcount=0, vcount=0; no pulse at reset release.
